// File: rtl/counters_pkg.sv
// Shared constants and the event record layout for the counter event logging path.
package counters_pkg;

   localparam int SIZE_DEF = 8;
   localparam int TS_W     = 16;

   localparam logic [1:0] SRC_RST1 = 2'b01;
   localparam logic [1:0] SRC_RST2 = 2'b10;
   localparam logic [1:0] SRC_BOTH = 2'b11;

   // Record layout at the default sum width; the log stores it flattened, src in the MSBs.
   typedef struct packed {
      logic [1:0]          src;
      logic [SIZE_DEF-1:0] sum;
      logic [TS_W-1:0]     ts;
   } event_rec_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous single-clock FIFO with full/empty flags and a combinational head read.
module event_fifo #(
   parameter int W     = 26,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/counter_event_log.sv
// Logs rising edges of the two reset-stage requests with the current sum and a timestamp.
module counter_event_log
   import counters_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] sum_in,
   input  logic            rst1_in,
   input  logic            rst2_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [1:0]      out_src,
   output logic [SIZE-1:0] out_sum,
   output logic [TS_W-1:0] out_time,
   output logic [7:0]      drop_cnt,
   output logic            overflow
);

   localparam int REC_W = 2 + SIZE + TS_W;

   logic [TS_W-1:0]  ts;
   logic             prev1;
   logic             prev2;
   logic [1:0]       rise;
   logic             ev;
   logic             pop;
   logic             push;
   logic             full;
   logic             empty;
   logic [REC_W-1:0] wrec;
   logic [REC_W-1:0] hrec;

   assign rise = {rst2_in & ~prev2, rst1_in & ~prev1};
   assign ev   = |rise;
   assign wrec = {rise, sum_in, ts};

   // Handshake: the head transfers on a cycle with out_valid=1 and out_ready=1; the head
   // fields hold while out_valid=1 without a transfer, and out_ready is ignored when empty.
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign push      = ev & (~full | pop);

   // Zeroed when empty so nothing stale shows during or after reset.
   assign {out_src, out_sum, out_time} = empty ? '0 : hrec;

   event_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wrec),
      .rdata (hrec),
      .full  (full),
      .empty (empty)
   );

   // Previous values reset high so requests already asserted at release are not events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts       <= '0;
         prev1    <= 1'b1;
         prev2    <= 1'b1;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         ts    <= ts + 16'd1;
         prev1 <= rst1_in;
         prev2 <= rst2_in;
         if (ev && !push) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_event_log.sv
// Directed bench for counter_event_log: edge capture, ordering, drops and reset behaviour.
module tb_counter_event_log;
   import counters_pkg::*;

   localparam int REC_W = 2 + SIZE_DEF + TS_W;

   logic                clk;
   logic                rst;
   logic [SIZE_DEF-1:0] sum_in;
   logic                rst1_in;
   logic                rst2_in;
   logic                out_valid;
   logic                out_ready;
   logic [1:0]          out_src;
   logic [SIZE_DEF-1:0] out_sum;
   logic [TS_W-1:0]     out_time;
   logic [7:0]          drop_cnt;
   logic                overflow;

   logic [TS_W-1:0]     ts_model;
   logic [REC_W-1:0]    exp_q[$];
   int                  checks;
   int                  errors;

   counter_event_log #(
      .SIZE  (SIZE_DEF),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sum_in    (sum_in),
      .rst1_in   (rst1_in),
      .rst2_in   (rst2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src),
      .out_sum   (out_sum),
      .out_time  (out_time),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) ts_model <= '0;
      else     ts_model <= ts_model + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // driver: one-cycle request pulse followed by a low cycle
   task automatic pulse(input logic [1:0] src, input logic [7:0] sum, input bit keep);
      sum_in  = sum;
      rst1_in = src[0];
      rst2_in = src[1];
      if (keep) exp_q.push_back({src, sum, ts_model});
      step();
      rst1_in = 1'b0;
      rst2_in = 1'b0;
      step();
   endtask

   // scoreboard: compare head against the expected queue, then pop it
   task automatic drain_one(input string tag);
      logic [REC_W-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_src"},   32'(out_src),   32'(e[REC_W-1 -: 2]));
      check({tag, "_sum"},   32'(out_sum),   32'(e[TS_W +: SIZE_DEF]));
      check({tag, "_time"},  32'(out_time),  32'(e[TS_W-1:0]));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [REC_W-1:0] e;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      sum_in    = '0;
      rst1_in   = 1'b0;
      rst2_in   = 1'b0;
      out_ready = 1'b0;
      step();
      step();

      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_drop",     32'(drop_cnt),  32'd0);
      check("rst_overflow", 32'(overflow),  32'd0);
      check("rst_time",     32'(out_time),  32'd0);
      check("rst_sum",      32'(out_sum),   32'd0);
      rst = 1'b0;

      // single rst1 rise captured at timestamp 10
      for (int i = 0; i < 20 && ts_model != 16'd10; i++) step();
      pulse(SRC_RST1, 8'd5, 1'b1);
      check("t10_time", 32'(out_time), 32'd10);
      drain_one("single");
      check("single_empty", 32'(out_valid), 32'd0);

      // simultaneous rise: one record with both source bits
      pulse(SRC_BOTH, 8'd9, 1'b1);
      drain_one("both");
      check("both_empty", 32'(out_valid), 32'd0);

      // six rises with no consumer: four held, two dropped
      for (int i = 1; i <= 6; i++) pulse(SRC_RST1, 8'(i), i <= 4);
      check("full_drop",     32'(drop_cnt), 32'd2);
      check("full_overflow", 32'(overflow), 32'd1);

      // event while full, coincident with a pop: accepted, lands last
      e = exp_q.pop_front();
      check("fullpop_head_sum", 32'(out_sum), 32'(e[TS_W +: SIZE_DEF]));
      check("fullpop_head_sum_hand", 32'(out_sum), 32'd1);
      out_ready = 1'b1;
      rst2_in   = 1'b1;
      sum_in    = 8'd7;
      exp_q.push_back({SRC_RST2, 8'd7, ts_model});
      step();
      out_ready = 1'b0;
      rst2_in   = 1'b0;
      step();
      check("fullpop_drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 4; i++) drain_one("order");
      check("order_empty", 32'(out_valid), 32'd0);

      // request held high across reset release gives no event
      rst1_in = 1'b1;
      rst     = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      step();
      check("held_valid",    32'(out_valid), 32'd0);
      check("held_drop",     32'(drop_cnt),  32'd0);
      check("held_overflow", 32'(overflow),  32'd0);
      rst1_in = 1'b0;
      step();
      pulse(SRC_RST1, 8'h33, 1'b1);
      drain_one("after_held");
      check("after_held_empty", 32'(out_valid), 32'd0);

      // reset with three entries pending
      for (int i = 0; i < 3; i++) pulse(SRC_RST1, 8'(8'h40 + i), 1'b1);
      check("pend_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_drop",  32'(drop_cnt),  32'd0);
      check("midrst_time",  32'(out_time),  32'd0);
      check("midrst_src",   32'(out_src),   32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      step();
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_drop",  32'(drop_cnt),  32'd0);
      pulse(SRC_RST1, 8'h44, 1'b1);
      check("post_time", 32'(out_time), 32'd1);
      drain_one("post");
      check("post_empty", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
